// File: rtl/rp_acq_wr.sv
// rp_acq_wr -- acquisition write controller for a circular sample buffer.
//
// Arms on arm_i, writes pre-trigger history, then waits for a trigger while
// continuing to fill the ring. After the trigger it writes post_len_i samples
// and parks in DONE. The write port is registered (one cycle latency).
//
// Optional feature macro: RP_ACQ_SMPCNT_EN
//   defined   -> smp_cnt_o counts writes since the last arm (saturating)
//   undefined -> smp_cnt_o is tied to zero and the counter is not built
//
// Ports
//   adc_clk_i, adc_rstn_i   clock (rising edge), async active-low reset
//   dly_dat_i, dly_val_i    trigger-aligned sample stream
//   arm_i, abort_i, trg_i   control pulses (priority abort > arm > trigger)
//   pre_len_i, post_len_i   pre/post trigger sample counts
//   buf_we_o/waddr_o/wdat_o buffer write port
//   trg_addr_o              buffer address of the trigger sample
//   armed_o, trg_seen_o, done_o, smp_cnt_o  status
module rp_acq_wr #(
  parameter int DW = 14,
  parameter int AW = 14
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic [DW-1:0] dly_dat_i,
  input  logic          dly_val_i,
  input  logic          arm_i,
  input  logic          abort_i,
  input  logic          trg_i,
  input  logic [AW:0]   pre_len_i,
  input  logic [31:0]   post_len_i,
  output logic          buf_we_o,
  output logic [AW-1:0] buf_waddr_o,
  output logic [DW-1:0] buf_wdat_o,
  output logic [AW-1:0] trg_addr_o,
  output logic          armed_o,
  output logic          trg_seen_o,
  output logic          done_o,
  output logic [31:0]   smp_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   PRE_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   pre_cnt;
  logic [31:0]   post_cnt;
  logic          armed_st;
  logic          wr_ok;

  assign armed_st = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  // arm and abort both consume their cycle: neither writes the sample that
  // arrives alongside them
  assign wr_ok    = armed_st & dly_val_i & ~arm_i & ~abort_i;

  // Registered buffer write port
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      buf_we_o    <= 1'b0;
      buf_waddr_o <= '0;
      buf_wdat_o  <= '0;
    end else begin
      buf_we_o <= wr_ok;
      if (wr_ok) begin
        buf_waddr_o <= ptr;
        buf_wdat_o  <= dly_dat_i;
      end else begin
        buf_waddr_o <= buf_waddr_o;
        buf_wdat_o  <= buf_wdat_o;
      end
    end
  end

  // Acquisition FSM with registered status flags, pointer and counters
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state      <= S_IDLE;
      ptr        <= '0;
      pre_cnt    <= '0;
      post_cnt   <= 32'd0;
      trg_addr_o <= '0;
      armed_o    <= 1'b0;
      trg_seen_o <= 1'b0;
      done_o     <= 1'b0;
    end else if (abort_i && armed_st) begin
      // abort only has something to abort while armed; DONE stays frozen
      state      <= S_IDLE;
      armed_o    <= 1'b0;
      trg_seen_o <= 1'b0;
      done_o     <= 1'b0;
    end else if (arm_i) begin
      state      <= S_PRE;
      ptr        <= '0;
      pre_cnt    <= (pre_len_i > DEPTH) ? DEPTH : pre_len_i;
      armed_o    <= 1'b1;
      trg_seen_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      if (wr_ok) begin
        ptr <= ptr + PTR_ONE;
      end else begin
        ptr <= ptr;
      end
      case (state)
        S_PRE: begin
          if (pre_cnt == '0) begin
            state <= S_WAIT;
          end else if (dly_val_i) begin
            pre_cnt <= pre_cnt - PRE_ONE;
            if (pre_cnt == PRE_ONE) begin
              state <= S_WAIT;
            end else begin
              state <= S_PRE;
            end
          end else begin
            state <= S_PRE;
          end
        end
        S_WAIT: begin
          if (trg_i) begin
            // a sample coinciding with the trigger is the trigger sample and
            // counts as the first post-trigger sample
            trg_addr_o <= ptr;
            trg_seen_o <= 1'b1;
            if ((post_len_i == 32'd0) || (dly_val_i && (post_len_i == 32'd1))) begin
              state   <= S_DONE;
              armed_o <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              post_cnt <= post_len_i - {31'd0, dly_val_i};
              state    <= S_POST;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_POST: begin
          if (dly_val_i) begin
            post_cnt <= post_cnt - 32'd1;
            if (post_cnt == 32'd1) begin
              state   <= S_DONE;
              armed_o <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              state <= S_POST;
            end
          end else begin
            state <= S_POST;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        S_IDLE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          armed_o <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RP_ACQ_SMPCNT_EN
  logic [31:0] smp_cnt;

  // Saturating count of writes since the last effective arm
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      smp_cnt <= 32'd0;
    end else if (arm_i && !(abort_i && armed_st)) begin
      smp_cnt <= 32'd0;
    end else if (wr_ok && (smp_cnt != 32'hFFFF_FFFF)) begin
      smp_cnt <= smp_cnt + 32'd1;
    end else begin
      smp_cnt <= smp_cnt;
    end
  end

  assign smp_cnt_o = smp_cnt;
`else
  assign smp_cnt_o = 32'd0;
`endif

endmodule
